// File: rtl/transform_engine.sv
// transform_engine: per-vertex scale, pitch/yaw/roll rotation and translation
// in signed fixed point. One vertex is in flight at a time. Each vertex takes
// one cycle per stage, so the latency is fixed. A disabled stage passes the
// coordinates through but still takes its cycle.
module transform_engine #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int ANGLE_BITS = 5
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WIDTH-1:0]      in_x,
  input  logic signed [WIDTH-1:0]      in_y,
  input  logic signed [WIDTH-1:0]      in_z,
  input  logic signed [WIDTH-1:0]      scale,
  input  logic signed [WIDTH-1:0]      x_trans,
  input  logic signed [WIDTH-1:0]      y_trans,
  input  logic signed [WIDTH-1:0]      z_trans,
  input  logic        [ANGLE_BITS-1:0] pitch,
  input  logic        [ANGLE_BITS-1:0] yaw,
  input  logic        [ANGLE_BITS-1:0] roll,
  input  logic        [4:0]            stage_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [WIDTH-1:0]      out_x,
  output logic signed [WIDTH-1:0]      out_y,
  output logic signed [WIDTH-1:0]      out_z
);

  localparam int ANG_N = 1 << ANGLE_BITS;
  localparam int QTR   = ANG_N / 4;

  typedef enum logic [2:0] {IDLE, SCALE, PITCH, YAW, ROLL, TRANS, OUT} state_t;

  state_t state, state_nx;

  // sin(2*pi*k/ANG_N) * 2^FRAC, rounded to nearest. Only the first quadrant is
  // evaluated; the other quadrants come from symmetry, so the quarter-turn
  // points are exact and the table is odd-symmetric.
  function automatic logic signed [WIDTH-1:0] sin_const(input int k);
    real    ang, term, sum, mag;
    int     q, r, m;
    longint v;
    q = (k / QTR) % 4;
    r = k % QTR;
    m = q[0] ? (QTR - r) : r;
    if (m == 0) begin
      mag = 0.0;
    end else if (m == QTR) begin
      mag = 1.0;
    end else begin
      ang  = (3.14159265358979323846 / 2.0) * m / QTR;
      term = ang;
      sum  = ang;
      for (int unsigned n = 1; n < 12; n++) begin
        term = -term * ang * ang / real'((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      mag = sum;
    end
    v = longint'(mag * (2.0 ** FRAC));
    if (q >= 2) v = -v;
    return WIDTH'(v);
  endfunction

  // Clamp a wide signed value to the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [2*WIDTH:0] v);
    logic [WIDTH+1:0] top;
    top = v[2*WIDTH:WIDTH-1];
    if ((&top) || !(|top)) return v[WIDTH-1:0];
    else if (v[2*WIDTH]) return {1'b1, {(WIDTH-1){1'b0}}};
    else return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Fixed-point multiply, floor shift and saturate.
  function automatic logic signed [WIDTH-1:0] mul_shift(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    logic signed [2*WIDTH:0]   e;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    e = (2*WIDTH+1)'(p);
    return sat(e >>> FRAC);
  endfunction

  // Saturating add with one guard bit.
  function automatic logic signed [WIDTH-1:0] add_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    return sat((2*WIDTH+1)'(s));
  endfunction

  logic signed [WIDTH-1:0] sin_tab [ANG_N];

  for (genvar k = 0; k < ANG_N; k++) begin : g_sin
    localparam logic signed [WIDTH-1:0] SIN_K = sin_const(k);
    assign sin_tab[k] = SIN_K;
  end

  logic signed [WIDTH-1:0] x_r, y_r, z_r;
  logic signed [WIDTH-1:0] scale_r, xt_r, yt_r, zt_r;
  logic [ANGLE_BITS-1:0]   pitch_r, yaw_r, roll_r;
  logic [4:0]              en_r;
  logic signed [WIDTH-1:0] nx, ny, nz;
  logic                    accept;

  logic [ANGLE_BITS-1:0]     ang_sel, cos_idx;
  logic signed [WIDTH-1:0]   rot_p, rot_q, sin_v, cos_v, rot_f, rot_g;
  logic signed [2*WIDTH-1:0] cp, sq, sp, cq;
  logic signed [2*WIDTH:0]   f_sum, g_sum;

  // One shared rotator computes f = c*p - s*q and g = s*p + c*q. Each axis
  // maps onto it by choosing (p,q): pitch (y,z), yaw (z,x), roll (x,y). For yaw,
  // f is the new z and g is the new x.
  always_comb begin
    ang_sel = roll_r;
    rot_p   = x_r;
    rot_q   = y_r;
    case (state)
      PITCH: begin
        ang_sel = pitch_r;
        rot_p   = y_r;
        rot_q   = z_r;
      end
      YAW: begin
        ang_sel = yaw_r;
        rot_p   = z_r;
        rot_q   = x_r;
      end
      default: ;
    endcase
    cos_idx = ang_sel + ANGLE_BITS'(QTR);
    sin_v   = sin_tab[ang_sel];
    cos_v   = sin_tab[cos_idx];
    cp      = (2*WIDTH)'(cos_v) * (2*WIDTH)'(rot_p);
    sq      = (2*WIDTH)'(sin_v) * (2*WIDTH)'(rot_q);
    sp      = (2*WIDTH)'(sin_v) * (2*WIDTH)'(rot_p);
    cq      = (2*WIDTH)'(cos_v) * (2*WIDTH)'(rot_q);
    f_sum   = (2*WIDTH+1)'(cp) - (2*WIDTH+1)'(sq);
    g_sum   = (2*WIDTH+1)'(sp) + (2*WIDTH+1)'(cq);
    rot_f   = sat(f_sum >>> FRAC);
    rot_g   = sat(g_sum >>> FRAC);
  end

  // Next state, handshake and per-stage coordinate update.
  always_comb begin
    state_nx = state;
    nx       = x_r;
    ny       = y_r;
    nz       = z_r;
    in_ready = !rst_in && ((state == IDLE) || ((state == OUT) && out_ready));
    case (state)
      IDLE: if (in_valid) state_nx = SCALE;
      SCALE: begin
        state_nx = PITCH;
        if (en_r[0]) begin
          nx = mul_shift(scale_r, x_r);
          ny = mul_shift(scale_r, y_r);
          nz = mul_shift(scale_r, z_r);
        end
      end
      PITCH: begin
        state_nx = YAW;
        if (en_r[1]) begin
          ny = rot_f;
          nz = rot_g;
        end
      end
      YAW: begin
        state_nx = ROLL;
        if (en_r[2]) begin
          nz = rot_f;
          nx = rot_g;
        end
      end
      ROLL: begin
        state_nx = TRANS;
        if (en_r[3]) begin
          nx = rot_f;
          ny = rot_g;
        end
      end
      TRANS: begin
        state_nx = OUT;
        if (en_r[4]) begin
          nx = add_sat(x_r, xt_r);
          ny = add_sat(y_r, yt_r);
          nz = add_sat(z_r, zt_r);
        end
      end
      OUT: if (out_ready) state_nx = in_valid ? SCALE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // State, coordinate and captured-config registers; accept snapshots config.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      scale_r <= '0;
      xt_r    <= '0;
      yt_r    <= '0;
      zt_r    <= '0;
      pitch_r <= '0;
      yaw_r   <= '0;
      roll_r  <= '0;
      en_r    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x_r     <= in_x;
        y_r     <= in_y;
        z_r     <= in_z;
        scale_r <= scale;
        xt_r    <= x_trans;
        yt_r    <= y_trans;
        zt_r    <= z_trans;
        pitch_r <= pitch;
        yaw_r   <= yaw;
        roll_r  <= roll;
        en_r    <= stage_en;
      end else begin
        x_r <= nx;
        y_r <= ny;
        z_r <= nz;
      end
    end
  end

  assign out_valid = (state == OUT);
  assign out_x     = x_r;
  assign out_y     = y_r;
  assign out_z     = z_r;

endmodule
